// File: rtl/iob_eth_tx_arbiter.sv
// Round-robin whole-frame arbiter sharing the MII TX nibble path between two sources.
// Defining IOB_ETH_TX_ARB_STATS_EN adds per-source clean-frame counters with a synchronous clear.
module iob_eth_tx_arbiter #(
    parameter int IFG_NIBBLES = 24,
    parameter int MAX_NIBBLES = 3044
`ifdef IOB_ETH_TX_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [3:0]       s0_data,
    input  logic             s0_valid,
    input  logic             s0_last,
    output logic             s0_ready,
    input  logic [3:0]       s1_data,
    input  logic             s1_valid,
    input  logic             s1_last,
    output logic             s1_ready,
    output logic [3:0]       tx_data,
    output logic             tx_en,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             underrun,
    output logic             oversize
`ifdef IOB_ETH_TX_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] s0_frames,
    output logic [CNT_W-1:0] s1_frames
`endif
);

    localparam int NIB_W = $clog2(MAX_NIBBLES + 1);
    localparam int GAP_W = (IFG_NIBBLES > 1) ? $clog2(IFG_NIBBLES) : 1;
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(MAX_NIBBLES - 1);
    localparam logic [NIB_W-1:0] NIB_MAX  = NIB_W'(MAX_NIBBLES);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XMIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_IFG   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [1:0]        ready_q, ready_d;
    logic [NIB_W-1:0]  nib_cnt_q, nib_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [3:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic              underrun_q, underrun_d;
    logic              oversize_q, oversize_d;

    logic              sel_valid;
    logic              sel_last;
    logic [3:0]        sel_data;
    logic              accept;
    logic              any_valid;
    logic              at_max;
    logic [1:0]        pick;

    // Route the granted source's stream onto a common set of signals.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 4'h0;
        case (grant_q)
            2'b01: begin
                sel_valid = s0_valid;
                sel_last  = s0_last;
                sel_data  = s0_data;
            end
            2'b10: begin
                sel_valid = s1_valid;
                sel_last  = s1_last;
                sel_data  = s1_data;
            end
            default: begin
                sel_valid = 1'b0;
                sel_last  = 1'b0;
                sel_data  = 4'h0;
            end
        endcase
    end

    assign accept    = sel_valid & (|ready_q);
    assign any_valid = s0_valid | s1_valid;
    assign at_max    = (nib_cnt_q == NIB_LAST);

    // Round-robin choice: on contention the source not served last wins.
    always_comb begin
        if (s0_valid && s1_valid) begin
            pick = (last_grant_q == 2'b01) ? 2'b10 : 2'b01;
        end else if (s0_valid) begin
            pick = 2'b01;
        end else if (s1_valid) begin
            pick = 2'b10;
        end else begin
            pick = 2'b00;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en && any_valid) state_d = ST_XMIT;
                else                 state_d = ST_IDLE;
            end
            ST_XMIT: begin
                if (!accept)             state_d = ST_DRAIN;
                else if (sel_last)       state_d = ST_IFG;
                else if (at_max)         state_d = ST_DRAIN;
                else                     state_d = ST_XMIT;
            end
            ST_DRAIN: begin
                if (accept && sel_last)  state_d = ST_IFG;
                else                     state_d = ST_DRAIN;
            end
            ST_IFG: begin
                if (gap_cnt_q == {GAP_W{1'b0}}) state_d = ST_IDLE;
                else                            state_d = ST_IFG;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; tx_en and the pulses default low every cycle.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        nib_cnt_d    = nib_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        tx_data_d    = tx_data_q;
        tx_en_d      = 1'b0;
        underrun_d   = 1'b0;
        oversize_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && any_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    nib_cnt_d    = {NIB_W{1'b0}};
                end else begin
                    grant_d      = grant_q;
                end
            end
            ST_XMIT: begin
                if (accept) begin
                    tx_data_d = sel_data;
                    tx_en_d   = 1'b1;
                    nib_cnt_d = (nib_cnt_q == NIB_MAX) ? nib_cnt_q : nib_cnt_q + NIB_W'(1);
                    if (sel_last) begin
                        gap_cnt_d = GAP_LOAD;
                    end else if (at_max) begin
                        oversize_d = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q;
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (accept && sel_last) gap_cnt_d = GAP_LOAD;
                else                    gap_cnt_d = gap_cnt_q;
            end
            ST_IFG: begin
                if (gap_cnt_q == {GAP_W{1'b0}}) grant_d   = 2'b00;
                else                            gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
            default: begin
                grant_d = 2'b00;
            end
        endcase
        ready_d = ((state_d == ST_XMIT) || (state_d == ST_DRAIN)) ? grant_d : 2'b00;
        busy_d  = (state_d != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= 2'b00;
            last_grant_q <= 2'b10;
            ready_q      <= 2'b00;
            nib_cnt_q    <= {NIB_W{1'b0}};
            gap_cnt_q    <= {GAP_W{1'b0}};
            tx_data_q    <= 4'h0;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
            oversize_q   <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ready_q      <= ready_d;
            nib_cnt_q    <= nib_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_en_q      <= tx_en_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
            oversize_q   <= oversize_d;
        end
    end

    assign s0_ready = ready_q[0];
    assign s1_ready = ready_q[1];
    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;
    assign oversize = oversize_q;

`ifdef IOB_ETH_TX_ARB_STATS_EN
    logic             clean_end_s;
    logic [CNT_W-1:0] s0_frames_q, s0_frames_d;
    logic [CNT_W-1:0] s1_frames_q, s1_frames_d;

    // Only a last nibble accepted while still transmitting counts as a clean frame.
    assign clean_end_s = (state_q == ST_XMIT) & accept & sel_last;

    // Clear wins over a same-cycle increment.
    always_comb begin
        if (stats_clr) begin
            s0_frames_d = {CNT_W{1'b0}};
            s1_frames_d = {CNT_W{1'b0}};
        end else begin
            s0_frames_d = s0_frames_q + ((clean_end_s & grant_q[0]) ? CNT_W'(1) : CNT_W'(0));
            s1_frames_d = s1_frames_q + ((clean_end_s & grant_q[1]) ? CNT_W'(1) : CNT_W'(0));
        end
    end

    // Frame counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_frames_q <= {CNT_W{1'b0}};
            s1_frames_q <= {CNT_W{1'b0}};
        end else begin
            s0_frames_q <= s0_frames_d;
            s1_frames_q <= s1_frames_d;
        end
    end

    assign s0_frames = s0_frames_q;
    assign s1_frames = s1_frames_q;
`endif

endmodule

// File: tb/tb_iob_eth_tx_arbiter.sv
// Directed bench for iob_eth_tx_arbiter: a per-cycle vector table for a single frame,
// then source-model sequences for round-robin, underrun, oversize, reset and enable.
module tb_iob_eth_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [3:0]  s0_data, s1_data;
    logic        s0_valid, s0_last, s0_ready;
    logic        s1_valid, s1_last, s1_ready;
    logic [3:0]  tx_data;
    logic        tx_en, busy, underrun, oversize;
    logic [1:0]  grant;
`ifdef IOB_ETH_TX_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] s0_frames, s1_frames;
`endif

    iob_eth_tx_arbiter #(.IFG_NIBBLES(24), .MAX_NIBBLES(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
        .tx_data(tx_data), .tx_en(tx_en), .grant(grant), .busy(busy),
        .underrun(underrun), .oversize(oversize)
`ifdef IOB_ETH_TX_ARB_STATS_EN
        , .stats_clr(stats_clr), .s0_frames(s0_frames), .s1_frames(s1_frames)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Source model: queued {last,data} nibbles; s1 can pause after hold_at1 accepts.
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    int   sent0, sent1;
    int   hold_at1 = -1;
    int   hold_cnt1 = 0;
    logic acc0 = 1'b0, acc1 = 1'b0;
    int   cyc = 0;

    // Monitor logs.
    logic [3:0] txq[$];
    int         runs[$];
    int         gaps[$];
    int         grants[$];
    int         n_und, n_ovs, hi_run, low_run;
    bit         seen_hi;
    logic [1:0] prev_grant;
    logic       prev_busy;
    int         last_acc_cyc, busy_fall_cyc;

    task automatic clear_mon();
        txq.delete(); runs.delete(); gaps.delete(); grants.delete();
        n_und = 0; n_ovs = 0; hi_run = 0; low_run = 0; seen_hi = 0;
        prev_grant = 2'b00; prev_busy = 1'b0;
        last_acc_cyc = 0; busy_fall_cyc = 0;
        sent0 = 0; sent1 = 0;
    endtask

    task automatic load(input int src, input int n, input int base);
        logic [4:0] nib;
        for (int i = 0; i < n; i++) begin
            nib = {(i == n - 1), 4'(base + i)};
            if (src == 0) q0.push_back(nib);
            else          q1.push_back(nib);
        end
    endtask

    // One cycle: retire last cycle's accepts, sample outputs, drive new inputs.
    task automatic tick();
        bit holding;
        @(negedge clk);
        cyc++;
        if (acc0) begin
            if (q0[0][4]) last_acc_cyc = cyc - 1;
            void'(q0.pop_front());
            sent0++;
        end
        if (acc1) begin
            if (q1[0][4]) last_acc_cyc = cyc - 1;
            void'(q1.pop_front());
            sent1++;
        end
        if (tx_en) begin
            txq.push_back(tx_data);
            if (seen_hi && low_run > 0) gaps.push_back(low_run);
            low_run = 0;
            seen_hi = 1;
            hi_run++;
        end else begin
            if (hi_run > 0) runs.push_back(hi_run);
            hi_run = 0;
            low_run++;
        end
        if (underrun) n_und++;
        if (oversize) n_ovs++;
        if (grant != 2'b00 && prev_grant == 2'b00) grants.push_back(int'(grant));
        prev_grant = grant;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
        holding = (sent1 == hold_at1) && (hold_cnt1 > 0);
        if (holding) hold_cnt1--;
        s0_valid = (q0.size() > 0);
        s0_data  = s0_valid ? q0[0][3:0] : 4'h0;
        s0_last  = s0_valid ? q0[0][4] : 1'b0;
        s1_valid = (q1.size() > 0) && !holding;
        s1_data  = (q1.size() > 0) ? q1[0][3:0] : 4'h0;
        s1_last  = (q1.size() > 0) ? q1[0][4] : 1'b0;
        acc0 = s0_valid && s0_ready;
        acc1 = s1_valid && s1_ready;
    endtask

    task automatic run_idle(input int max_cyc, input string nm);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            tick();
            if (q0.size() == 0 && q1.size() == 0 && !busy && !acc0 && !acc1) break;
        end
        if (k == max_cyc) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d cycles expected fewer than %0d", nm, k, max_cyc);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_tx_en"}, tx_en, 0);
        chk({nm, "_tx_data"}, tx_data, 0);
        chk({nm, "_grant"}, grant, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_underrun"}, underrun, 0);
        chk({nm, "_oversize"}, oversize, 0);
        chk({nm, "_s0_ready"}, s0_ready, 0);
        chk({nm, "_s1_ready"}, s1_ready, 0);
    endtask

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       l;
        logic       e_en;
        logic [3:0] e_d;
        logic [1:0] e_g;
        logic       e_r;
        logic       e_b;
    } vec_t;

    vec_t tbl[34];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int saw_busy;

        // Single s0 frame 1..8: grant cycle, 8 data cycles, 24-cycle gap, back to idle.
        tbl[0] = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 2'b01, 1'b1, 1'b1};
        for (int k = 2; k <= 8; k++)
            tbl[k] = '{1'b1, 4'(k), 1'(k == 8), 1'b1, 4'(k - 1), 2'b01, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd8, 2'b01, 1'b0, 1'b1};
        for (int k = 10; k <= 32; k++)
            tbl[k] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 2'b01, 1'b0, 1'b1};
        tbl[33] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b1;
        s0_valid = 1'b0; s0_data = 4'h0; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = 4'h0; s1_last = 1'b0;
`ifdef IOB_ETH_TX_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        clear_mon();
        repeat (3) tick();
        chk_reset_vals("por");
        rst = 1'b0;

        for (int r = 0; r < 34; r++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_tx_en", r), tx_en, tbl[r].e_en);
            if (tbl[r].e_en) chk($sformatf("tbl%0d_tx_data", r), tx_data, tbl[r].e_d);
            chk($sformatf("tbl%0d_grant", r), grant, tbl[r].e_g);
            chk($sformatf("tbl%0d_s0_ready", r), s0_ready, tbl[r].e_r);
            chk($sformatf("tbl%0d_s1_ready", r), s1_ready, 0);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_b);
            chk($sformatf("tbl%0d_pulses", r), {underrun, oversize}, 0);
            s0_valid = tbl[r].v;
            s0_data  = tbl[r].d;
            s0_last  = tbl[r].l;
        end

        // Back-to-back contention after reset: s0,s1,s0,s1 with 25 idle cycles between.
        rst = 1'b1;
        acc0 = 1'b0; acc1 = 1'b0;
        tick();
        rst = 1'b0;
        clear_mon();
        load(0, 4, 1); load(0, 4, 9);
        load(1, 4, 5); load(1, 4, 13);
        run_idle(400, "b2b");
        chk("b2b_grants_n", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++)
            chk($sformatf("b2b_grant%0d", i), grants[i], (i % 2 == 0) ? 1 : 2);
        chk("b2b_runs_n", runs.size(), 4);
        for (int i = 0; i < runs.size(); i++) chk($sformatf("b2b_run%0d", i), runs[i], 4);
        chk("b2b_gaps_n", gaps.size(), 3);
        for (int i = 0; i < gaps.size(); i++) chk($sformatf("b2b_gap%0d", i), gaps[i], 25);
        chk("b2b_tx_n", txq.size(), 16);
        for (int i = 0; i < txq.size(); i++)
            chk($sformatf("b2b_data%0d", i), txq[i], (i + 1) % 16);
        chk("b2b_underrun", n_und, 0);

        // s1 pauses after 3 of 10 nibbles: underrun, drain to last, then a full gap.
        clear_mon();
        load(1, 10, 3);
        hold_at1 = 3; hold_cnt1 = 4;
        run_idle(200, "und");
        hold_at1 = -1;
        chk("und_runs_n", runs.size(), 1);
        if (runs.size() > 0) chk("und_run_len", runs[0], 3);
        for (int i = 0; i < txq.size(); i++) chk($sformatf("und_data%0d", i), txq[i], 3 + i);
        chk("und_pulses", n_und, 1);
        chk("und_oversize", n_ovs, 0);
        chk("und_grant", (grants.size() > 0) ? grants[0] : 0, 2);
        chk("und_ifg", busy_fall_cyc - last_acc_cyc, 25);

        // 20-nibble s0 frame with a 16-nibble limit.
        clear_mon();
        load(0, 20, 0);
        run_idle(200, "ovs");
        chk("ovs_tx_n", txq.size(), 16);
        for (int i = 0; i < txq.size(); i++) chk($sformatf("ovs_data%0d", i), txq[i], i % 16);
        chk("ovs_runs_n", runs.size(), 1);
        chk("ovs_pulses", n_ovs, 1);
        chk("ovs_underrun", n_und, 0);
        chk("ovs_ifg", busy_fall_cyc - last_acc_cyc, 25);

        // Reset while s1 sends its 5th nibble.
        clear_mon();
        load(1, 10, 0);
        for (int k = 0; k < 50 && sent1 < 4; k++) tick();
        chk("rstmid_sent", sent1, 4);
        chk("rstmid_pre_tx_en", tx_en, 1);
        chk("rstmid_pre_tx_data", tx_data, 3);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rstmid");
        rst = 1'b0;
        q1.delete();
        acc0 = 1'b0; acc1 = 1'b0;

        // Both valid while disabled: nothing granted; once enabled, s0 goes first.
        clear_mon();
        en = 1'b0;
        load(0, 4, 10); load(1, 4, 5);
        saw_busy = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy) saw_busy++;
        end
        chk("dis_grants", grants.size(), 0);
        chk("dis_busy", saw_busy, 0);
        en = 1'b1;
        run_idle(200, "ena");
        chk("ena_grants_n", grants.size(), 2);
        chk("ena_first", (grants.size() > 0) ? grants[0] : 0, 1);
        chk("ena_tx_n", txq.size(), 8);
        for (int i = 0; i < txq.size(); i++)
            chk($sformatf("ena_data%0d", i), txq[i], (i < 4) ? 10 + i : 1 + i);

`ifdef IOB_ETH_TX_ARB_STATS_EN
        chk("st_pre_s0", s0_frames, 1);
        chk("st_pre_s1", s1_frames, 1);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("st_clr0_s0", s0_frames, 0);
        chk("st_clr0_s1", s1_frames, 0);
        clear_mon();
        load(0, 4, 0); load(0, 4, 4); load(0, 4, 8);
        run_idle(300, "st_s0");
        load(1, 10, 0);
        hold_at1 = 3; hold_cnt1 = 4;
        run_idle(200, "st_s1");
        hold_at1 = -1;
        chk("st_und", n_und, 1);
        chk("st_s0", s0_frames, 3);
        chk("st_s1", s1_frames, 0);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("st_clr1_s0", s0_frames, 0);
        chk("st_clr1_s1", s1_frames, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
